// File: rtl/lcd_hd44780_rx.sv
// HD44780-compatible LCD controller model seen from the bus side: decodes host
// E-strobe transactions into instruction/data accesses on DDRAM and CGRAM.
module lcd_hd44780_rx #(
    parameter int CMD_CYCLES   = 1850,
    parameter int CLEAR_CYCLES = 76500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    input  logic       disp_row,
    input  logic [3:0] disp_col,
    output logic [7:0] disp_char,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       entry_shift,
    output logic       func_dl,
    output logic       func_n,
    output logic       func_f,
    output logic [5:0] disp_shift,
    output logic       cmd_err
);

    localparam int MAXC = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] CMD_LOAD = CW'(CMD_CYCLES - 1);
    localparam logic [CW-1:0] CLR_LOAD = CW'(CLEAR_CYCLES - 1);

    logic [10:0] syncA_q, syncB_q;
    logic        ePrev_q;
    logic        eS, rsS, rwS, eFall;
    logic [7:0]  datS;

    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    ac_q, ac_d;
    logic [5:0]    cg_q, cg_d;
    logic          cgMode_q, cgMode_d;
    logic          fill_q, fill_d;
    logic [4:0]    fillIdx_q, fillIdx_d;
    logic          dispOn_q, dispOn_d, cursorOn_q, cursorOn_d, blinkOn_q, blinkOn_d;
    logic          entryInc_q, entryInc_d, entryShift_q, entryShift_d;
    logic          funcDl_q, funcDl_d, funcN_q, funcN_d, funcF_q, funcF_d;
    logic [5:0]    shift_q, shift_d;
    logic          cmdErr_q, cmdErr_d;
    logic [7:0]    dispChar_q;

    logic [7:0] ddram [32];
    logic [7:0] cgram [64];
    logic       ddWe, cgWe, stepEn, stepUp;
    logic [4:0] ddIdx;
    logic [7:0] ddWdata, rdData;

    assign {eS, rsS, rwS, datS} = syncB_q;
    assign eFall = ePrev_q & ~eS;

    function automatic logic [6:0] ddStep(input logic [6:0] a, input logic up);
        if (up) begin
            if (a == 7'h27) return 7'h40;
            if (a == 7'h67) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h00) return 7'h67;
        if (a == 7'h40) return 7'h27;
        return a - 7'd1;
    endfunction

    function automatic logic [5:0] shiftStep(input logic [5:0] s, input logic up);
        if (up) return (s == 6'd39) ? 6'd0 : s + 6'd1;
        return (s == 6'd0) ? 6'd39 : s - 6'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncA_q <= '0;
            syncB_q <= '0;
            ePrev_q <= 1'b0;
        end else begin
            syncA_q <= {lcd_e, lcd_rs, lcd_rw, lcd_data_in};
            syncB_q <= syncA_q;
            ePrev_q <= eS;
        end
    end

    always_comb begin
        busy_d       = busy_q;
        cnt_d        = cnt_q;
        ac_d         = ac_q;
        cg_d         = cg_q;
        cgMode_d     = cgMode_q;
        fill_d       = fill_q;
        fillIdx_d    = fillIdx_q;
        dispOn_d     = dispOn_q;
        cursorOn_d   = cursorOn_q;
        blinkOn_d    = blinkOn_q;
        entryInc_d   = entryInc_q;
        entryShift_d = entryShift_q;
        funcDl_d     = funcDl_q;
        funcN_d      = funcN_q;
        funcF_d      = funcF_q;
        shift_d      = shift_q;
        cmdErr_d     = 1'b0;
        ddWe         = 1'b0;
        ddIdx        = {ac_q[6], ac_q[3:0]};
        ddWdata      = datS;
        cgWe         = 1'b0;
        stepEn       = 1'b0;
        stepUp       = entryInc_q;

        if (fill_q) begin
            ddWe      = 1'b1;
            ddIdx     = fillIdx_q;
            ddWdata   = 8'h20;
            fillIdx_d = fillIdx_q + 5'd1;
            if (fillIdx_q == 5'd31) fill_d = 1'b0;
        end

        if (busy_q) begin
            if (cnt_q == '0) busy_d = 1'b0;
            else             cnt_d  = cnt_q - CW'(1);
        end

        // Status reads are always served and never touch state.
        if (eFall && !(rwS && !rsS)) begin
            if (busy_q) begin
                cmdErr_d = 1'b1;
            end else if (rsS) begin
                busy_d = 1'b1;
                cnt_d  = CMD_LOAD;
                stepEn = 1'b1;
                if (!rwS) begin
                    if (cgMode_q) cgWe = 1'b1;
                    else begin
                        ddWe = (ac_q[5:4] == 2'b00);
                        if (entryShift_q) shift_d = shiftStep(shift_q, entryInc_q);
                    end
                end
            end else begin
                busy_d = 1'b1;
                cnt_d  = CMD_LOAD;
                if (datS[7]) begin
                    if (datS[5:0] >= 6'h28) begin
                        cmdErr_d = 1'b1;
                        busy_d   = 1'b0;
                        cnt_d    = cnt_q;
                    end else begin
                        cgMode_d = 1'b0;
                        ac_d     = datS[6:0];
                    end
                end else if (datS[6]) begin
                    cgMode_d = 1'b1;
                    cg_d     = datS[5:0];
                end else if (datS[5]) begin
                    funcDl_d = datS[4];
                    funcN_d  = datS[3];
                    funcF_d  = datS[2];
                    cmdErr_d = ~datS[4];
                end else if (datS[4]) begin
                    if (datS[3]) shift_d = shiftStep(shift_q, datS[2]);
                    else begin
                        stepEn = 1'b1;
                        stepUp = datS[2];
                    end
                end else if (datS[3]) begin
                    dispOn_d   = datS[2];
                    cursorOn_d = datS[1];
                    blinkOn_d  = datS[0];
                end else if (datS[2]) begin
                    entryInc_d   = datS[1];
                    entryShift_d = datS[0];
                end else if (datS[1]) begin
                    ac_d     = 7'h00;
                    cgMode_d = 1'b0;
                    shift_d  = 6'd0;
                    cnt_d    = CLR_LOAD;
                end else if (datS[0]) begin
                    fill_d     = 1'b1;
                    fillIdx_d  = 5'd0;
                    ac_d       = 7'h00;
                    cgMode_d   = 1'b0;
                    entryInc_d = 1'b1;
                    shift_d    = 6'd0;
                    cnt_d      = CLR_LOAD;
                end else begin
                    cmdErr_d = 1'b1;
                    busy_d   = 1'b0;
                    cnt_d    = cnt_q;
                end
            end
        end

        if (stepEn) begin
            if (cgMode_q) cg_d = stepUp ? cg_q + 6'd1 : cg_q - 6'd1;
            else          ac_d = ddStep(ac_q, stepUp);
        end
    end

    // Reset leaves busy high with the clear fill pending, as after power-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= 1'b1;
            cnt_q        <= CLR_LOAD;
            ac_q         <= 7'h00;
            cg_q         <= 6'd0;
            cgMode_q     <= 1'b0;
            fill_q       <= 1'b1;
            fillIdx_q    <= 5'd0;
            dispOn_q     <= 1'b0;
            cursorOn_q   <= 1'b0;
            blinkOn_q    <= 1'b0;
            entryInc_q   <= 1'b1;
            entryShift_q <= 1'b0;
            funcDl_q     <= 1'b1;
            funcN_q      <= 1'b0;
            funcF_q      <= 1'b0;
            shift_q      <= 6'd0;
            cmdErr_q     <= 1'b0;
            dispChar_q   <= 8'h00;
        end else begin
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            ac_q         <= ac_d;
            cg_q         <= cg_d;
            cgMode_q     <= cgMode_d;
            fill_q       <= fill_d;
            fillIdx_q    <= fillIdx_d;
            dispOn_q     <= dispOn_d;
            cursorOn_q   <= cursorOn_d;
            blinkOn_q    <= blinkOn_d;
            entryInc_q   <= entryInc_d;
            entryShift_q <= entryShift_d;
            funcDl_q     <= funcDl_d;
            funcN_q      <= funcN_d;
            funcF_q      <= funcF_d;
            shift_q      <= shift_d;
            cmdErr_q     <= cmdErr_d;
            dispChar_q   <= ddram[{disp_row, disp_col}];
        end
    end

    always_ff @(posedge clk) begin
        if (ddWe) ddram[ddIdx] <= ddWdata;
        if (cgWe) cgram[cg_q] <= datS;
    end

    // Unstored DDRAM columns 16-39 read back as blanks.
    assign rdData = cgMode_q ? cgram[cg_q]
                  : ((ac_q[5:4] == 2'b00) ? ddram[{ac_q[6], ac_q[3:0]}] : 8'h20);

    assign ac           = cgMode_q ? {1'b0, cg_q} : ac_q;
    assign lcd_data_oe  = eS & rwS;
    assign lcd_data_out = lcd_data_oe ? (rsS ? rdData : {busy_q, ac}) : 8'h00;
    assign disp_char    = dispChar_q;
    assign busy         = busy_q;
    assign disp_on      = dispOn_q;
    assign cursor_on    = cursorOn_q;
    assign blink_on     = blinkOn_q;
    assign entry_inc    = entryInc_q;
    assign entry_shift  = entryShift_q;
    assign func_dl      = funcDl_q;
    assign func_n       = funcN_q;
    assign func_f       = funcF_q;
    assign disp_shift   = shift_q;
    assign cmd_err      = cmdErr_q;

endmodule
